debug_controller: RTL and testbench

DEBUG_CONTROLLER -- requirements
Module: debug_controller

---
 rtl/debug_controller_if.sv | 32 +++
 rtl/debug_controller.sv | 208 ++++++++++++++++++++
 tb/tb_debug_controller.sv | 531 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_controller_if.sv
// Host command port plus the sequencer/core debug signals of the debug controller.
// The master side is the host/sequencer environment; the slave side is the controller.
interface debug_controller_if;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_data;
  logic        cmd_ready;
  logic        done;
  logic        err;
  logic [15:0] pc_addr;
  logic [15:0] mem_addr;
  logic        mem_wr;
  logic        debug_ack;
  logic        debug_active;
  logic        debug_req;
  logic        debug_mode_stop;
  logic        debug_mode_inc;
  logic        debug_at_bkp;
  logic        debug_in_watch;

  modport master (
    output cmd_valid, cmd_op, cmd_data, pc_addr, mem_addr, mem_wr, debug_ack, debug_active,
    input  cmd_ready, done, err, debug_req, debug_mode_stop, debug_mode_inc,
           debug_at_bkp, debug_in_watch
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, pc_addr, mem_addr, mem_wr, debug_ack, debug_active,
    output cmd_ready, done, err, debug_req, debug_mode_stop, debug_mode_inc,
           debug_at_bkp, debug_in_watch
  );
endinterface

// File: rtl/debug_controller.sv
// Debug controller: accepts host commands, runs a REQ/ACK step handshake with the
// sequencer (with an 8-bit timeout), and tracks one breakpoint and one watchpoint.
module debug_controller (
  input  logic              clk,
  input  logic              rst,
  debug_controller_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, REL, GAP} state_t;

  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_STOP      = 3'd1;
  localparam logic [2:0] OP_RUN       = 3'd2;
  localparam logic [2:0] OP_STEP      = 3'd3;
  localparam logic [2:0] OP_SET_BKP   = 3'd4;
  localparam logic [2:0] OP_CLR_BKP   = 3'd5;
  localparam logic [2:0] OP_SET_WATCH = 3'd6;
  localparam logic [2:0] OP_CLR_WATCH = 3'd7;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;

  state_t      state_q, state_d;
  logic [7:0]  count_q, count_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        stop_q, stop_d;
  logic        inc_q, inc_d;
  logic [15:0] bkp_addr_q, bkp_addr_d;
  logic        bkp_en_q, bkp_en_d;
  logic [15:0] watch_addr_q, watch_addr_d;
  logic        watch_en_q, watch_en_d;
  logic        skip_q, skip_d;
  logic [15:0] skip_pc_q, skip_pc_d;
  logic        at_bkp_q, at_bkp_d;
  logic        in_watch_q, in_watch_d;

  logic        run_acc;
  logic        clr_watch_acc;
  logic        watch_hit;
  logic [7:0]  tmo_inc;

  assign tmo_inc = tmo_q + 8'd1;

  // Command decode and step handshake FSM; the timeout aborts when the counter reaches 255.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    tmo_d         = tmo_q;
    done_d        = 1'b0;
    err_d         = err_q;
    stop_d        = stop_q;
    inc_d         = inc_q;
    bkp_addr_d    = bkp_addr_q;
    bkp_en_d      = bkp_en_q;
    watch_addr_d  = watch_addr_q;
    watch_en_d    = watch_en_q;
    run_acc       = 1'b0;
    clr_watch_acc = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          done_d = 1'b1;
          case (bus.cmd_op)
            OP_NOP:  err_d = 1'b0;
            OP_STOP: stop_d = 1'b1;
            OP_RUN: begin
              stop_d  = 1'b0;
              run_acc = 1'b1;
            end
            OP_STEP: begin
              if (bus.debug_active && (bus.cmd_data[7:0] != 8'd0)) begin
                done_d  = 1'b0;
                count_d = bus.cmd_data[7:0];
                inc_d   = bus.cmd_data[8];
                tmo_d   = 8'd0;
                state_d = REQ;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_SET_BKP: begin
              bkp_addr_d = bus.cmd_data;
              bkp_en_d   = 1'b1;
            end
            OP_CLR_BKP: bkp_en_d = 1'b0;
            OP_SET_WATCH: begin
              watch_addr_d = bus.cmd_data;
              watch_en_d   = 1'b1;
            end
            OP_CLR_WATCH: begin
              watch_en_d    = 1'b0;
              clr_watch_acc = 1'b1;
            end
            default: ;
          endcase
        end
      end
      REQ: begin
        if (bus.debug_ack) begin
          state_d = REL;
          count_d = count_q - 8'd1;
          tmo_d   = 8'd0;
        end else if (tmo_inc == TIMEOUT_LIMIT) begin
          state_d = IDLE;
          tmo_d   = tmo_inc;
          err_d   = 1'b1;
          done_d  = 1'b1;
          inc_d   = 1'b0;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      REL: begin
        if (!bus.debug_ack) begin
          state_d = GAP;
        end else if (tmo_inc == TIMEOUT_LIMIT) begin
          state_d = IDLE;
          tmo_d   = tmo_inc;
          err_d   = 1'b1;
          done_d  = 1'b1;
          inc_d   = 1'b0;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      GAP: begin
        if (count_q != 8'd0) begin
          state_d = REQ;
          tmo_d   = 8'd0;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
          inc_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Breakpoint skip tracking, registered breakpoint compare and sticky watchpoint (set wins).
  always_comb begin
    skip_d    = skip_q;
    skip_pc_d = skip_pc_q;
    if (run_acc && at_bkp_q) begin
      skip_d    = 1'b1;
      skip_pc_d = bus.pc_addr;
    end else if (skip_q && (bus.pc_addr != skip_pc_q)) begin
      skip_d = 1'b0;
    end
    at_bkp_d  = bkp_en_q && (bus.pc_addr == bkp_addr_q) && !skip_d;
    watch_hit = watch_en_q && bus.mem_wr && (bus.mem_addr == watch_addr_q);
    in_watch_d = in_watch_q;
    if (run_acc || clr_watch_acc) begin
      in_watch_d = 1'b0;
    end
    if (watch_hit) begin
      in_watch_d = 1'b1;
    end
  end

  // State register for everything above; reset abandons any step in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      count_q      <= 8'd0;
      tmo_q        <= 8'd0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      stop_q       <= 1'b0;
      inc_q        <= 1'b0;
      bkp_addr_q   <= 16'd0;
      bkp_en_q     <= 1'b0;
      watch_addr_q <= 16'd0;
      watch_en_q   <= 1'b0;
      skip_q       <= 1'b0;
      skip_pc_q    <= 16'd0;
      at_bkp_q     <= 1'b0;
      in_watch_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      tmo_q        <= tmo_d;
      done_q       <= done_d;
      err_q        <= err_d;
      stop_q       <= stop_d;
      inc_q        <= inc_d;
      bkp_addr_q   <= bkp_addr_d;
      bkp_en_q     <= bkp_en_d;
      watch_addr_q <= watch_addr_d;
      watch_en_q   <= watch_en_d;
      skip_q       <= skip_d;
      skip_pc_q    <= skip_pc_d;
      at_bkp_q     <= at_bkp_d;
      in_watch_q   <= in_watch_d;
    end
  end

  assign bus.cmd_ready       = (state_q == IDLE);
  assign bus.debug_req       = (state_q == REQ);
  assign bus.done            = done_q;
  assign bus.err             = err_q;
  assign bus.debug_mode_stop = stop_q;
  assign bus.debug_mode_inc  = inc_q;
  assign bus.debug_at_bkp    = at_bkp_q;
  assign bus.debug_in_watch  = in_watch_q;

endmodule

// File: tb/tb_debug_controller.sv
// Self-checking bench for debug_controller: randomized commands, step handshakes,
// timeout, breakpoint and watchpoint scenarios against a behavioural model.
module tb_debug_controller;

  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_STOP      = 3'd1;
  localparam logic [2:0] OP_RUN       = 3'd2;
  localparam logic [2:0] OP_STEP      = 3'd3;
  localparam logic [2:0] OP_SET_BKP   = 3'd4;
  localparam logic [2:0] OP_CLR_BKP   = 3'd5;
  localparam logic [2:0] OP_SET_WATCH = 3'd6;
  localparam logic [2:0] OP_CLR_WATCH = 3'd7;

  logic clk = 1'b0;
  logic rst;
  int   tests_run    = 0;
  int   tests_failed = 0;

  debug_controller_if bus ();

  debug_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.cmd_valid    = 1'b0;
    bus.cmd_op       = OP_NOP;
    bus.cmd_data     = 16'd0;
    bus.pc_addr      = 16'd0;
    bus.mem_addr     = 16'd0;
    bus.mem_wr       = 1'b0;
    bus.debug_ack    = 1'b0;
    bus.debug_active = 1'b0;
  endtask

  // Called at a falling edge; returns at the falling edge right after acceptance.
  task automatic send_cmd(input logic [2:0] op, input logic [15:0] data);
    int waited;
    waited = 0;
    while (bus.cmd_ready !== 1'b1 && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 1000) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL send_cmd_ready: cmd_ready stayed %b, required 1", bus.cmd_ready);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] obs;
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    obs = {bus.cmd_ready, bus.done, bus.err, bus.debug_req, bus.debug_mode_stop,
           bus.debug_mode_inc, bus.debug_at_bkp, bus.debug_in_watch};
    tests_run++;
    if (obs !== 8'b1000_0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got %b required %b", obs, 8'b1000_0000);
    end
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.cmd_ready !== 1'b1 || bus.done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_release: ready=%b done=%b required ready=1 done=0",
               bus.cmd_ready, bus.done);
    end
  endtask

  task automatic test_random_cmds();
    logic       exp_err;
    logic       exp_stop;
    logic [2:0] op;
    exp_err  = 1'b0;
    exp_stop = 1'b0;
    bus.debug_active = 1'b0;
    for (int i = 0; i < 20; i++) begin
      op = 3'($urandom_range(0, 7));
      send_cmd(op, 16'($urandom));
      case (op)
        OP_NOP:  exp_err = 1'b0;
        OP_STOP: exp_stop = 1'b1;
        OP_RUN:  exp_stop = 1'b0;
        OP_STEP: exp_err = 1'b1;
        default: ;
      endcase
      tests_run++;
      if (bus.done !== 1'b1 || bus.err !== exp_err || bus.debug_mode_stop !== exp_stop) begin
        tests_failed++;
        $display("[TB] FAIL random_cmd op=%0d: done=%b err=%b stop=%b required done=1 err=%b stop=%b",
                 op, bus.done, bus.err, bus.debug_mode_stop, exp_err, exp_stop);
      end
    end
  endtask

  task automatic test_step();
    int         rises;
    int         req_cnt;
    int         delay;
    logic [7:0] n;
    logic       inc_b;
    logic       prev_req;
    logic       inc_bad;
    logic       finished;
    send_cmd(OP_NOP, 16'd0);
    bus.debug_active = 1'b1;
    for (int it = 0; it < 3; it++) begin
      if (it == 0) begin
        n     = 8'd3;
        inc_b = 1'b1;
        delay = 4;
      end else begin
        n     = 8'($urandom_range(1, 6));
        inc_b = 1'($urandom_range(0, 1));
        delay = $urandom_range(1, 6);
      end
      send_cmd(OP_STOP, 16'd0);
      tests_run++;
      if (bus.debug_mode_stop !== 1'b1 || bus.done !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL step_stop: stop=%b done=%b required 1 1", bus.debug_mode_stop, bus.done);
      end
      send_cmd(OP_STEP, {7'd0, inc_b, n});
      rises    = 0;
      req_cnt  = 0;
      prev_req = 1'b0;
      inc_bad  = 1'b0;
      finished = 1'b0;
      for (int c = 0; c < 2000 && !finished; c++) begin
        if (bus.debug_req && !prev_req) rises++;
        prev_req = bus.debug_req;
        if (bus.done) begin
          finished = 1'b1;
        end else if (bus.debug_mode_inc !== inc_b) begin
          inc_bad = 1'b1;
        end
        if (bus.debug_req) begin
          req_cnt++;
          bus.debug_ack = (req_cnt >= delay);
        end else begin
          req_cnt = 0;
          bus.debug_ack = 1'b0;
        end
        @(negedge clk);
      end
      tests_run++;
      if (!finished || rises != int'(n)) begin
        tests_failed++;
        $display("[TB] FAIL step_req_edges n=%0d: done_seen=%b rises=%0d required done_seen=1 rises=%0d",
                 n, finished, rises, n);
      end
      tests_run++;
      if (inc_bad || bus.err !== 1'b0 || bus.done !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL step_status: inc_bad=%b err=%b done_after=%b required 0 0 0",
                 inc_bad, bus.err, bus.done);
      end
      tests_run++;
      if (bus.cmd_ready !== 1'b1 || bus.debug_mode_inc !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL step_idle: ready=%b inc=%b required 1 0", bus.cmd_ready, bus.debug_mode_inc);
      end
    end
  endtask

  task automatic test_timeout();
    int   req_cycles;
    logic finished;
    logic err_at, ready_at, req_at;
    bus.debug_active = 1'b1;
    bus.debug_ack    = 1'b0;
    send_cmd(OP_STEP, 16'h0001);
    req_cycles = 0;
    finished   = 1'b0;
    err_at     = 1'b0;
    ready_at   = 1'b0;
    req_at     = 1'b1;
    for (int c = 0; c < 400 && !finished; c++) begin
      if (bus.done) begin
        finished = 1'b1;
        err_at   = bus.err;
        ready_at = bus.cmd_ready;
        req_at   = bus.debug_req;
      end else begin
        if (bus.debug_req) req_cycles++;
        @(negedge clk);
      end
    end
    tests_run++;
    if (!finished || req_cycles != 255) begin
      tests_failed++;
      $display("[TB] FAIL timeout_len: done_seen=%b req_cycles=%0d required 1 255", finished, req_cycles);
    end
    tests_run++;
    if (err_at !== 1'b1 || ready_at !== 1'b1 || req_at !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL timeout_state: err=%b ready=%b req=%b required 1 1 0", err_at, ready_at, req_at);
    end
    send_cmd(OP_NOP, 16'd0);
    tests_run++;
    if (bus.err !== 1'b0 || bus.done !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL timeout_nop_clear: err=%b done=%b required 0 1", bus.err, bus.done);
    end
  endtask

  task automatic test_step_error();
    logic saw_req;
    bus.debug_active = 1'b0;
    send_cmd(OP_STEP, 16'($urandom_range(1, 255)));
    saw_req = bus.debug_req;
    tests_run++;
    if (bus.done !== 1'b1 || bus.err !== 1'b1 || bus.cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL step_inactive: done=%b err=%b ready=%b required 1 1 1",
               bus.done, bus.err, bus.cmd_ready);
    end
    repeat (5) begin
      @(negedge clk);
      if (bus.debug_req) saw_req = 1'b1;
    end
    tests_run++;
    if (saw_req !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL step_inactive_req: debug_req seen=%b required 0", saw_req);
    end
    send_cmd(OP_NOP, 16'd0);
    bus.debug_active = 1'b1;
    send_cmd(OP_STEP, 16'h0100);
    tests_run++;
    if (bus.err !== 1'b1 || bus.done !== 1'b1 || bus.debug_req !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL step_zero: err=%b done=%b req=%b required 1 1 0", bus.err, bus.done, bus.debug_req);
    end
    send_cmd(OP_NOP, 16'd0);
  endtask

  task automatic test_reset_mid_step();
    logic [7:0] obs;
    logic       got_req;
    logic       bad_after;
    bus.debug_active = 1'b1;
    bus.debug_ack    = 1'b0;
    send_cmd(OP_STOP, 16'd0);
    send_cmd(OP_STEP, 16'h0105);
    got_req = 1'b0;
    for (int c = 0; c < 20 && !got_req; c++) begin
      if (bus.debug_req) got_req = 1'b1;
      else @(negedge clk);
    end
    bus.debug_ack = 1'b1;
    @(negedge clk);
    tests_run++;
    if (!got_req || bus.debug_req !== 1'b0 || bus.cmd_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mid_step_rel: req_seen=%b req=%b ready=%b required 1 0 0",
               got_req, bus.debug_req, bus.cmd_ready);
    end
    #2 rst = 1'b1;
    #1;
    obs = {bus.cmd_ready, bus.done, bus.err, bus.debug_req, bus.debug_mode_stop,
           bus.debug_mode_inc, bus.debug_at_bkp, bus.debug_in_watch};
    tests_run++;
    if (obs !== 8'b1000_0000) begin
      tests_failed++;
      $display("[TB] FAIL mid_step_reset_async: got %b required %b", obs, 8'b1000_0000);
    end
    @(negedge clk);
    obs = {bus.cmd_ready, bus.done, bus.err, bus.debug_req, bus.debug_mode_stop,
           bus.debug_mode_inc, bus.debug_at_bkp, bus.debug_in_watch};
    tests_run++;
    if (obs !== 8'b1000_0000) begin
      tests_failed++;
      $display("[TB] FAIL mid_step_reset_hold: got %b required %b", obs, 8'b1000_0000);
    end
    rst = 1'b0;
    bus.debug_ack = 1'b0;
    bad_after = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done || bus.debug_req) bad_after = 1'b1;
    end
    tests_run++;
    if (bad_after !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mid_step_abandon: done/req after reset=%b required 0", bad_after);
    end
  endtask

  task automatic test_bkp();
    logic [15:0] a;
    logic [15:0] seq [0:2];
    logic [15:0] prev_pc;
    logic        exp_hit;
    a = 16'($urandom_range(16, 65520));
    bus.pc_addr = a - 16'd2;
    send_cmd(OP_SET_BKP, a);
    seq[0] = a - 16'd1;
    seq[1] = a;
    seq[2] = a;
    for (int i = 0; i < 3; i++) begin
      prev_pc     = seq[i];
      bus.pc_addr = seq[i];
      @(negedge clk);
      exp_hit = (prev_pc == a);
      tests_run++;
      if (bus.debug_at_bkp !== exp_hit) begin
        tests_failed++;
        $display("[TB] FAIL bkp_approach pc=%h: at_bkp=%b required %b", prev_pc, bus.debug_at_bkp, exp_hit);
      end
    end
    send_cmd(OP_RUN, 16'd0);
    tests_run++;
    if (bus.debug_at_bkp !== 1'b0 || bus.done !== 1'b1 || bus.debug_mode_stop !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bkp_run: at_bkp=%b done=%b stop=%b required 0 1 0",
               bus.debug_at_bkp, bus.done, bus.debug_mode_stop);
    end
    seq[0] = a;
    seq[1] = a + 16'd1;
    seq[2] = a + 16'd1;
    for (int i = 0; i < 3; i++) begin
      bus.pc_addr = seq[i];
      @(negedge clk);
      tests_run++;
      if (bus.debug_at_bkp !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL bkp_skip pc=%h: at_bkp=%b required 0", seq[i], bus.debug_at_bkp);
      end
    end
    bus.pc_addr = a;
    @(negedge clk);
    tests_run++;
    if (bus.debug_at_bkp !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL bkp_rehit: at_bkp=%b required 1", bus.debug_at_bkp);
    end
    send_cmd(OP_CLR_BKP, 16'd0);
    @(negedge clk);
    tests_run++;
    if (bus.debug_at_bkp !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bkp_cleared: at_bkp=%b required 0", bus.debug_at_bkp);
    end
  endtask

  task automatic test_watch();
    logic [15:0] w;
    logic        exp_w;
    logic        held;
    logic        wr;
    logic [15:0] addr;
    w = 16'($urandom_range(1, 65535));
    send_cmd(OP_SET_WATCH, w);
    bus.mem_addr = w - 16'd1;
    bus.mem_wr   = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.debug_in_watch !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL watch_near_miss: in_watch=%b required 0", bus.debug_in_watch);
    end
    bus.mem_addr = w;
    @(negedge clk);
    bus.mem_wr = 1'b0;
    tests_run++;
    if (bus.debug_in_watch !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL watch_hit: in_watch=%b required 1", bus.debug_in_watch);
    end
    held = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.debug_in_watch !== 1'b1) held = 1'b0;
    end
    tests_run++;
    if (held !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL watch_sticky: held=%b required 1", held);
    end
    bus.mem_wr = 1'b1;
    send_cmd(OP_RUN, 16'd0);
    bus.mem_wr = 1'b0;
    tests_run++;
    if (bus.debug_in_watch !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL watch_set_beats_run: in_watch=%b required 1", bus.debug_in_watch);
    end
    send_cmd(OP_RUN, 16'd0);
    tests_run++;
    if (bus.debug_in_watch !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL watch_run_clear: in_watch=%b required 0", bus.debug_in_watch);
    end
    exp_w = 1'b0;
    for (int i = 0; i < 30; i++) begin
      wr = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 2))
        0:       addr = w;
        1:       addr = w ^ 16'h0001;
        default: addr = 16'($urandom);
      endcase
      bus.mem_wr   = wr;
      bus.mem_addr = addr;
      if (wr && addr == w) exp_w = 1'b1;
      @(negedge clk);
      tests_run++;
      if (bus.debug_in_watch !== exp_w) begin
        tests_failed++;
        $display("[TB] FAIL watch_random cycle %0d: in_watch=%b required %b", i, bus.debug_in_watch, exp_w);
      end
    end
    bus.mem_wr = 1'b0;
    send_cmd(OP_CLR_WATCH, 16'd0);
    bus.mem_addr = w;
    bus.mem_wr   = 1'b1;
    @(negedge clk);
    bus.mem_wr = 1'b0;
    tests_run++;
    if (bus.debug_in_watch !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL watch_disabled: in_watch=%b required 0", bus.debug_in_watch);
    end
  endtask

  task automatic test_back_to_back();
    int   req_cnt;
    logic finished;
    logic ready_bad;
    logic err_bad;
    bus.debug_active = 1'b0;
    send_cmd(OP_STEP, 16'h0002);
    bus.debug_active = 1'b1;
    bus.debug_ack    = 1'b0;
    send_cmd(OP_STEP, 16'h0002);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_NOP;
    bus.cmd_data  = 16'd0;
    req_cnt   = 0;
    finished  = 1'b0;
    ready_bad = 1'b0;
    err_bad   = 1'b0;
    for (int c = 0; c < 200 && !finished; c++) begin
      if (bus.done) begin
        finished = 1'b1;
      end else begin
        if (bus.cmd_ready !== 1'b0) ready_bad = 1'b1;
        if (bus.err !== 1'b1) err_bad = 1'b1;
        if (bus.debug_req) begin
          req_cnt++;
          bus.debug_ack = (req_cnt >= 2);
        end else begin
          req_cnt = 0;
          bus.debug_ack = 1'b0;
        end
        @(negedge clk);
      end
    end
    tests_run++;
    if (!finished || ready_bad || err_bad) begin
      tests_failed++;
      $display("[TB] FAIL b2b_busy: done_seen=%b ready_while_busy=%b early_nop=%b required 1 0 0",
               finished, ready_bad, err_bad);
    end
    tests_run++;
    if (bus.err !== 1'b1 || bus.cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL b2b_step_done: err=%b ready=%b required 1 1", bus.err, bus.cmd_ready);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    tests_run++;
    if (bus.done !== 1'b1 || bus.err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_nop_after: done=%b err=%b required 1 0", bus.done, bus.err);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_STOP;
    @(negedge clk);
    bus.cmd_op = OP_RUN;
    tests_run++;
    if (bus.done !== 1'b1 || bus.debug_mode_stop !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL b2b_stop: done=%b stop=%b required 1 1", bus.done, bus.debug_mode_stop);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    tests_run++;
    if (bus.done !== 1'b1 || bus.debug_mode_stop !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_run: done=%b stop=%b required 1 0", bus.done, bus.debug_mode_stop);
    end
    @(negedge clk);
    tests_run++;
    if (bus.done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_done_pulse: done=%b required 0", bus.done);
    end
  endtask

  // Test sequence and summary.
  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_random_cmds();
    test_step();
    test_timeout();
    test_step_error();
    test_reset_mid_step();
    test_bkp();
    test_watch();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
